issue_sched: RTL and testbench
==============================

Name: issue_sched

Overview:
- Dual-issue scheduler and scoreboard for the SPU-Lite even pipe (EP) and odd pipe (OP), placed between decode and register-fetch.
- Each cycle it takes the decoded instruction pair and decides which instructions issue, and to which pipe.
- An instruction is held while any of its source registers matches an in-flight destination whose result is not yet forwardable.
- It tracks EP/OP destinations through stages 2..7 plus writeback, matching the stage set the forwarding network can source from.

Parameters:
- ADDR_WD, 7, register address width (128 registers)
- NUM_STG, 7, last pipeline stage tracked before writeback
- CNT_WD, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid_0/1  in  1  slot valid; slot 0 is older
- pipe_0/1  in  1  target pipe: 0 = EP, 1 = OP
- ra_addr_0/1, rb_addr_0/1, rc_addr_0/1  in  7  source addresses
- src_en_0/1  in  3  source used: bit2 = ra, bit1 = rb, bit0 = rc
- rt_addr_0/1  in  7  destination address
- wr_en_0/1  in  1  instruction writes rt
- lat_0/1  in  3  first stage at which the result is forwardable (2..7)
- flush  in  1  branch mispredict kill
- accept_0/1  out  1  slot issues this cycle; decode re-presents unaccepted slots
- ep_issue  out  1  an instruction enters EP
- ep_slot  out  1  which slot drives EP
- op_issue  out  1  an instruction enters OP
- op_slot  out  1  which slot drives OP
- stall  out  1  in_valid_0 && !accept_0
- stall_cnt  out  CNT_WD  saturating count of stall cycles

Behaviour:
- Reset: all scoreboard entries invalid; every output is 0; stall_cnt = 0.
- Scoreboard: two shift chains (EP and OP), one entry each for stages s2..s7 and wb. Entry fields: {v, wr, addr, lat}.
  - An issued instruction is at stage 1 in its issue cycle and loads s2 on the next edge.
  - Each edge shifts s(k) to s(k+1), s7 to wb; wb is dropped.
  - Non-issuing pipe: s2 loads v = 0.
- Ready rule: an entry at stage k blocks a reader of addr when v && wr && k < lat. wb entries never block. lat < 2 is treated as 2.
- Slot 0 is blocked when:
  - any enabled source matches a blocking entry in either chain.
- Slot 1 is blocked when any of these hold:
  - any enabled source matches a blocking entry in either chain;
  - wr_en_0 && rt_addr_0 equals an enabled slot-1 source (intra-pair RAW);
  - wr_en_0 && wr_en_1 && rt_addr_0 == rt_addr_1 (WAW);
  - pipe_1 == pipe_0 (structural).
- Issue order is in-order:
  - accept_0 = in_valid_0 && !blk0 && !flush;
  - accept_1 = accept_0 && in_valid_1 && !blk1.
  - A slot-1 instruction never issues without slot 0.
- Pipe mapping, same-cycle combinational from the inputs and current scoreboard state:
  - ep_issue/op_issue assert for the pipe of each accepted slot;
  - ep_slot/op_slot give the index of that slot.
- Flush: forces accept_0/1 = 0 this cycle and clears v of both s2 entries on the same edge. Deeper stages are untouched.
- stall_cnt increments on every cycle with stall = 1 and holds at all-ones. It is not cleared by flush.
- rst asserted mid-operation clears all entries on the next edge regardless of flush or stall.
- Multiple matching entries: any single blocking match stalls; age among entries is irrelevant to the stall decision.

Test Plan:
1. Back-to-back dependency:
   - Cycle 0: EP fixed-point, rt = 5, lat = 2. Cycle 1: ra = 5.
   - Required: accept_0 = 1 in cycle 1 (producer at s2 ≥ 2); stall_cnt = 0.
2. Long-latency stall:
   - OP producer, rt = 9, lat = 6, issued in cycle 0. Next instruction reads rb = 9.
   - Required: stall = 1 in cycles 1..4; accept_0 = 1 in cycle 5; stall_cnt = 4.
3. Pair conflicts:
   - Slot 0 EP rt = 3 and slot 1 OP ra = 3 -> only accept_0.
   - Repeat with slot 1 ra = 4 -> both accepted, ep_slot = 0, op_slot = 1.
   - Both slots pipe = 1 -> accept_1 = 0.
4. Flush:
   - Issue rt = 7 with lat = 7; assert flush next cycle; following cycle read ra = 7.
   - Required: accept_0 = 1 with no stall (s2 entry cleared) and accept = 0 during the flush cycle.
5. Reset mid-stall:
   - While stalled in scenario 2 at cycle 2, pulse rst.
   - Required: next cycle all outputs 0, scoreboard empty, stall_cnt = 0, and the re-presented reader issues immediately.
6. Saturation:
   - Force 65 540 stall cycles.
   - Required: stall_cnt = 16'hFFFF and holds.

Source files
------------

// File: rtl/issue_sched.sv
// Dual-issue scheduler for the EP/OP pipes: picks which decoded slots issue and
// holds readers of results that the forwarding network cannot yet supply.
module issue_sched #(
    parameter int ADDR_WD = 7,
    parameter int NUM_STG = 7,
    parameter int CNT_WD  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_0,
    input  logic               in_valid_1,
    input  logic               pipe_0,
    input  logic               pipe_1,
    input  logic [ADDR_WD-1:0] ra_addr_0,
    input  logic [ADDR_WD-1:0] ra_addr_1,
    input  logic [ADDR_WD-1:0] rb_addr_0,
    input  logic [ADDR_WD-1:0] rb_addr_1,
    input  logic [ADDR_WD-1:0] rc_addr_0,
    input  logic [ADDR_WD-1:0] rc_addr_1,
    input  logic [2:0]         src_en_0,
    input  logic [2:0]         src_en_1,
    input  logic [ADDR_WD-1:0] rt_addr_0,
    input  logic [ADDR_WD-1:0] rt_addr_1,
    input  logic               wr_en_0,
    input  logic               wr_en_1,
    input  logic [2:0]         lat_0,
    input  logic [2:0]         lat_1,
    input  logic               flush,
    output logic               accept_0,
    output logic               accept_1,
    output logic               ep_issue,
    output logic               ep_slot,
    output logic               op_issue,
    output logic               op_slot,
    output logic               stall,
    output logic [CNT_WD-1:0]  stall_cnt
);

    // Index i holds stage i+2; the last index is writeback.
    localparam int DEPTH = NUM_STG;

    typedef struct packed {
        logic               v;
        logic               wr;
        logic [ADDR_WD-1:0] addr;
        logic [2:0]         lat;
    } ent_t;

    ent_t              r_ep [DEPTH];
    ent_t              r_op [DEPTH];
    logic [CNT_WD-1:0] r_stall_cnt;

    logic w_blk0_sb;
    logic w_blk1_sb;
    logic w_blk0;
    logic w_blk1;
    logic w_acc0;
    logic w_acc1;
    logic w_ep_issue;
    logic w_ep_slot;
    logic w_op_issue;
    logic w_op_slot;
    logic w_stall;
    ent_t w_ep_new;
    ent_t w_op_new;

    function automatic logic reads(input logic [2:0] en,
                                   input logic [ADDR_WD-1:0] ra,
                                   input logic [ADDR_WD-1:0] rb,
                                   input logic [ADDR_WD-1:0] rc,
                                   input logic [ADDR_WD-1:0] addr);
        return (en[2] && (ra == addr)) || (en[1] && (rb == addr)) || (en[0] && (rc == addr));
    endfunction

    function automatic logic blocks(input ent_t e, input int stg);
        logic [2:0] lat_eff;
        lat_eff = (e.lat < 3'd2) ? 3'd2 : e.lat;
        return e.v && e.wr && (stg < int'(lat_eff));
    endfunction

    always_comb begin
        w_blk0_sb = 1'b0;
        w_blk1_sb = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (blocks(r_ep[i], i + 2)) begin
                w_blk0_sb = w_blk0_sb | reads(src_en_0, ra_addr_0, rb_addr_0, rc_addr_0, r_ep[i].addr);
                w_blk1_sb = w_blk1_sb | reads(src_en_1, ra_addr_1, rb_addr_1, rc_addr_1, r_ep[i].addr);
            end
            if (blocks(r_op[i], i + 2)) begin
                w_blk0_sb = w_blk0_sb | reads(src_en_0, ra_addr_0, rb_addr_0, rc_addr_0, r_op[i].addr);
                w_blk1_sb = w_blk1_sb | reads(src_en_1, ra_addr_1, rb_addr_1, rc_addr_1, r_op[i].addr);
            end
        end
    end

    assign w_blk0 = w_blk0_sb;
    assign w_blk1 = w_blk1_sb
                  || (wr_en_0 && reads(src_en_1, ra_addr_1, rb_addr_1, rc_addr_1, rt_addr_0))
                  || (wr_en_0 && wr_en_1 && (rt_addr_0 == rt_addr_1))
                  || (pipe_1 == pipe_0);

    // Outputs are held at zero while reset is asserted.
    assign w_acc0 = !rst && in_valid_0 && !w_blk0 && !flush;
    assign w_acc1 = w_acc0 && in_valid_1 && !w_blk1;

    assign w_ep_issue = (w_acc0 && !pipe_0) || (w_acc1 && !pipe_1);
    assign w_ep_slot  = w_acc1 && !pipe_1;
    assign w_op_issue = (w_acc0 && pipe_0) || (w_acc1 && pipe_1);
    assign w_op_slot  = w_acc1 && pipe_1;
    assign w_stall    = !rst && in_valid_0 && !w_acc0;

    always_comb begin
        w_ep_new = '0;
        w_op_new = '0;
        if (w_ep_issue) begin
            w_ep_new.v    = 1'b1;
            w_ep_new.wr   = w_ep_slot ? wr_en_1   : wr_en_0;
            w_ep_new.addr = w_ep_slot ? rt_addr_1 : rt_addr_0;
            w_ep_new.lat  = w_ep_slot ? lat_1     : lat_0;
        end
        if (w_op_issue) begin
            w_op_new.v    = 1'b1;
            w_op_new.wr   = w_op_slot ? wr_en_1   : wr_en_0;
            w_op_new.addr = w_op_slot ? rt_addr_1 : rt_addr_0;
            w_op_new.lat  = w_op_slot ? lat_1     : lat_0;
        end
    end

    // A flush kills the instruction sitting in s2 as it moves on to s3.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ep[i] <= '0;
                r_op[i] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            r_ep[0] <= w_ep_new;
            r_op[0] <= w_op_new;
            r_ep[1] <= r_ep[0];
            r_op[1] <= r_op[0];
            if (flush) begin
                r_ep[1].v <= 1'b0;
                r_op[1].v <= 1'b0;
            end
            for (int i = 2; i < DEPTH; i++) begin
                r_ep[i] <= r_ep[i-1];
                r_op[i] <= r_op[i-1];
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_WD'(1);
            end
        end
    end

    assign accept_0  = w_acc0;
    assign accept_1  = w_acc1;
    assign ep_issue  = w_ep_issue;
    assign ep_slot   = w_ep_slot;
    assign op_issue  = w_op_issue;
    assign op_slot   = w_op_slot;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_sched.sv
// Bench for issue_sched: a cycle-by-cycle vector table with hand-derived
// expectations, followed by a long flush-held run to saturate stall_cnt.
module tb_issue_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_0, in_valid_1, pipe_0, pipe_1;
    logic [6:0]  ra_addr_0, ra_addr_1, rb_addr_0, rb_addr_1, rc_addr_0, rc_addr_1;
    logic [2:0]  src_en_0, src_en_1;
    logic [6:0]  rt_addr_0, rt_addr_1;
    logic        wr_en_0, wr_en_1;
    logic [2:0]  lat_0, lat_1;
    logic        flush;
    logic        accept_0, accept_1, ep_issue, ep_slot, op_issue, op_slot, stall;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    issue_sched dut (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
        .pipe_0(pipe_0), .pipe_1(pipe_1),
        .ra_addr_0(ra_addr_0), .ra_addr_1(ra_addr_1),
        .rb_addr_0(rb_addr_0), .rb_addr_1(rb_addr_1),
        .rc_addr_0(rc_addr_0), .rc_addr_1(rc_addr_1),
        .src_en_0(src_en_0), .src_en_1(src_en_1),
        .rt_addr_0(rt_addr_0), .rt_addr_1(rt_addr_1),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1),
        .lat_0(lat_0), .lat_1(lat_1),
        .flush(flush),
        .accept_0(accept_0), .accept_1(accept_1),
        .ep_issue(ep_issue), .ep_slot(ep_slot),
        .op_issue(op_issue), .op_slot(op_slot),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic       v;
        logic       p;
        logic [6:0] ra, rb, rc;
        logic [2:0] en;
        logic [6:0] rt;
        logic       wr;
        logic [2:0] lat;
    } slot_t;

    // exp = {accept_0, accept_1, ep_issue, ep_slot, op_issue, op_slot, stall}
    typedef struct {
        slot_t      s0;
        slot_t      s1;
        logic       fl;
        logic       rs;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        logic [6:0]  outs;
        logic [15:0] cnt;
    } exp_t;

    localparam slot_t NONE = '0;

    vec_t  tv[$];
    exp_t  sb[$];
    int    n_pass = 0;
    int    n_total = 0;
    logic [15:0] cnt_model = 16'd0;

    function automatic slot_t S(input logic p, input logic [6:0] ra, input logic [6:0] rb,
                                input logic [6:0] rc, input logic [2:0] en, input logic [6:0] rt,
                                input logic wr, input logic [2:0] lat);
        slot_t s;
        s.v = 1'b1; s.p = p; s.ra = ra; s.rb = rb; s.rc = rc;
        s.en = en; s.rt = rt; s.wr = wr; s.lat = lat;
        return s;
    endfunction

    function automatic vec_t V(input slot_t a, input slot_t b, input logic fl,
                               input logic rs, input logic [6:0] e);
        vec_t t;
        t.s0 = a; t.s1 = b; t.fl = fl; t.rs = rs; t.exp = e;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        in_valid_0 = t.s0.v;  pipe_0 = t.s0.p;
        ra_addr_0 = t.s0.ra;  rb_addr_0 = t.s0.rb; rc_addr_0 = t.s0.rc;
        src_en_0 = t.s0.en;   rt_addr_0 = t.s0.rt; wr_en_0 = t.s0.wr; lat_0 = t.s0.lat;
        in_valid_1 = t.s1.v;  pipe_1 = t.s1.p;
        ra_addr_1 = t.s1.ra;  rb_addr_1 = t.s1.rb; rc_addr_1 = t.s1.rc;
        src_en_1 = t.s1.en;   rt_addr_1 = t.s1.rt; wr_en_1 = t.s1.wr; lat_1 = t.s1.lat;
        flush = t.fl;
        rst = t.rs;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic compare_front(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        check({name, " outs"}, 32'({accept_0, accept_1, ep_issue, ep_slot, op_issue, op_slot, stall}),
              32'(e.outs));
        check({name, " stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    endtask

    initial begin
        slot_t rd9, rd14, rd15, rd17, nop_ep, nop_op;
        vec_t  t;
        nop_ep = S(0, 0, 0, 0, 3'b000, 0, 0, 2);
        nop_op = S(1, 0, 0, 0, 3'b000, 0, 0, 2);
        rd9    = S(0, 0, 9, 0, 3'b010, 0, 0, 2);
        rd14   = S(0, 14, 0, 0, 3'b100, 0, 0, 2);
        rd15   = S(0, 15, 0, 0, 3'b100, 0, 0, 2);
        rd17   = S(1, 0, 0, 17, 3'b001, 0, 0, 2);

        tv.push_back(V(S(0, 2, 0, 0, 3'b100, 2, 1, 2), NONE, 0, 1, 7'b0000000));
        // back-to-back, lat 2
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 5, 1, 2), NONE, 0, 0, 7'b1010000));
        tv.push_back(V(S(0, 5, 0, 0, 3'b100, 6, 0, 2), NONE, 0, 0, 7'b1010000));
        // long-latency OP producer, four stall cycles
        tv.push_back(V(S(1, 0, 0, 0, 3'b000, 9, 1, 6), NONE, 0, 0, 7'b1000100));
        for (int i = 0; i < 4; i++) tv.push_back(V(rd9, NONE, 0, 0, 7'b0000001));
        tv.push_back(V(rd9, NONE, 0, 0, 7'b1010000));
        // pair conflicts
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 3, 1, 3), S(1, 3, 0, 0, 3'b100, 0, 0, 2), 0, 0, 7'b1010000));
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 10, 1, 2), S(1, 4, 0, 0, 3'b100, 11, 1, 2), 0, 0, 7'b1110110));
        tv.push_back(V(S(1, 0, 0, 0, 3'b000, 12, 1, 2), S(0, 20, 0, 0, 3'b100, 0, 0, 2), 0, 0, 7'b1111100));
        tv.push_back(V(nop_op, nop_op, 0, 0, 7'b1000100));
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 13, 1, 2), S(1, 0, 0, 0, 3'b000, 13, 1, 2), 0, 0, 7'b1010000));
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 14, 1, 5), NONE, 0, 0, 7'b1010000));
        tv.push_back(V(nop_op, rd14, 0, 0, 7'b1000100));
        tv.push_back(V(NONE, nop_op, 0, 0, 7'b0000000));
        tv.push_back(V(rd14, nop_op, 0, 0, 7'b0000001));
        tv.push_back(V(rd14, S(1, 0, 0, 14, 3'b001, 0, 0, 2), 0, 0, 7'b1110110));
        // flush kills the s2 entry
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 7, 1, 7), NONE, 0, 0, 7'b1010000));
        tv.push_back(V(nop_op, NONE, 1, 0, 7'b0000001));
        tv.push_back(V(S(0, 7, 0, 0, 3'b100, 0, 0, 2), NONE, 0, 0, 7'b1010000));
        // flush leaves deeper stages alone
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 15, 1, 7), NONE, 0, 0, 7'b1010000));
        tv.push_back(V(nop_op, NONE, 0, 0, 7'b1000100));
        tv.push_back(V(nop_op, NONE, 1, 0, 7'b0000001));
        for (int i = 0; i < 3; i++) tv.push_back(V(rd15, NONE, 0, 0, 7'b0000001));
        tv.push_back(V(rd15, NONE, 0, 0, 7'b1010000));
        // lat 3 blocks only at s2
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 17, 1, 3), NONE, 0, 0, 7'b1010000));
        tv.push_back(V(rd17, NONE, 0, 0, 7'b0000001));
        tv.push_back(V(rd17, NONE, 0, 0, 7'b1000100));
        // reset mid-stall
        tv.push_back(V(S(1, 0, 0, 0, 3'b000, 9, 1, 6), NONE, 0, 0, 7'b1000100));
        tv.push_back(V(rd9, NONE, 0, 0, 7'b0000001));
        tv.push_back(V(rd9, NONE, 0, 0, 7'b0000001));
        tv.push_back(V(rd9, NONE, 0, 1, 7'b0000000));
        tv.push_back(V(rd9, NONE, 0, 0, 7'b1010000));
        // two blocking entries in different chains
        tv.push_back(V(S(0, 0, 0, 0, 3'b000, 20, 1, 4), S(1, 0, 0, 0, 3'b000, 21, 1, 4), 0, 0, 7'b1110110));
        tv.push_back(V(S(0, 20, 21, 0, 3'b110, 0, 0, 2), NONE, 0, 0, 7'b0000001));
        tv.push_back(V(S(0, 20, 21, 0, 3'b110, 0, 0, 2), NONE, 0, 0, 7'b0000001));
        tv.push_back(V(S(0, 20, 21, 0, 3'b110, 0, 0, 2), NONE, 0, 0, 7'b1010000));

        drive(V(NONE, NONE, 0, 1, 7'b0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            t = tv[i];
            #1;
            drive(t);
            sb.push_back('{outs: t.exp, cnt: cnt_model});
            @(negedge clk);
            compare_front($sformatf("vec%0d", i));
            if (t.rs) cnt_model = 16'd0;
            else if (t.exp[0] && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
            @(posedge clk);
        end

        // Hold flush with a valid slot 0 so every cycle is a stall cycle.
        #1;
        drive(V(nop_ep, NONE, 1, 0, 7'b0));
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        end
        sb.push_back('{outs: 7'b0000001, cnt: cnt_model});
        @(negedge clk);
        compare_front("sat");
        check("sat value", 32'(stall_cnt), 32'hFFFF);
        repeat (5) @(posedge clk);
        sb.push_back('{outs: 7'b0000001, cnt: 16'hFFFF});
        @(negedge clk);
        compare_front("sat hold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
